// File: rtl/msrv32_machine_control.sv
// ============================================================================
//  Module   : msrv32_machine_control
//  Purpose  : Trap/interrupt sequencer that sits after msrv32_dec. It steers the
//             PC mux, the flush line and the mcause/mepc/mstatus updates.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module msrv32_machine_control #(
    parameter int CAUSE_W = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               illegal_instr_in,
    input  logic               misaligned_load_in,
    input  logic               misaligned_store_in,
    input  logic               misaligned_instr_in,
    input  logic [4:0]         opcode_6_to_2_in,
    input  logic [2:0]         funct3_in,
    input  logic [6:0]         funct7_in,
    input  logic [4:0]         rs2_addr_in,
    input  logic               mie_in,
    input  logic               meie_in,
    input  logic               mtie_in,
    input  logic               msie_in,
    input  logic               meip_in,
    input  logic               mtip_in,
    input  logic               msip_in,
    output logic               trap_taken_out,
    output logic               i_or_e_out,
    output logic [CAUSE_W-1:0] cause_out,
    output logic               set_cause_out,
    output logic               set_epc_out,
    output logic               mie_clear_out,
    output logic               mie_set_out,
    output logic               instret_inc_out,
    output logic [1:0]         pc_src_out,
    output logic               flush_out
);

    typedef enum logic [1:0] {
        ST_RESET       = 2'b00,
        ST_OPERATING   = 2'b01,
        ST_TRAP_TAKEN  = 2'b10,
        ST_TRAP_RETURN = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic                 i_or_e_q, i_or_e_d;

    logic                 w_system;
    logic                 w_ecall;
    logic                 w_ebreak;
    logic                 w_mret;
    logic                 w_exc;
    logic [CAUSE_W-1:0]   w_exc_cause;
    logic                 w_ext_irq;
    logic                 w_sw_irq;
    logic                 w_tmr_irq;
    logic                 w_irq;
    logic [CAUSE_W-1:0]   w_irq_cause;

    assign w_system = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000);
    assign w_ecall  = w_system && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'b00000);
    assign w_ebreak = w_system && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'b00001);
    assign w_mret   = w_system && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'b00010);

    assign w_exc = misaligned_instr_in | illegal_instr_in | w_ebreak | w_ecall |
                   misaligned_load_in  | misaligned_store_in;

    // Exception priority chain, highest first.
    always_comb begin
        w_exc_cause = CAUSE_W'(6);
        if (misaligned_instr_in)      w_exc_cause = CAUSE_W'(0);
        else if (illegal_instr_in)    w_exc_cause = CAUSE_W'(2);
        else if (w_ebreak)            w_exc_cause = CAUSE_W'(3);
        else if (w_ecall)             w_exc_cause = CAUSE_W'(11);
        else if (misaligned_load_in)  w_exc_cause = CAUSE_W'(4);
        else                          w_exc_cause = CAUSE_W'(6);
    end

    assign w_ext_irq = meie_in & meip_in;
    assign w_sw_irq  = msie_in & msip_in;
    assign w_tmr_irq = mtie_in & mtip_in;
    assign w_irq     = mie_in & (w_ext_irq | w_sw_irq | w_tmr_irq);

    always_comb begin
        w_irq_cause = CAUSE_W'(7);
        if (w_ext_irq)     w_irq_cause = CAUSE_W'(11);
        else if (w_sw_irq) w_irq_cause = CAUSE_W'(3);
        else               w_irq_cause = CAUSE_W'(7);
    end

    // Events are only sampled in OPERATING; the two trap states are one-shot.
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        i_or_e_d = i_or_e_q;
        case (state_q)
            ST_RESET: state_d = ST_OPERATING;
            ST_OPERATING: begin
                if (w_exc) begin
                    cause_d  = w_exc_cause;
                    i_or_e_d = 1'b0;
                    state_d  = ST_TRAP_TAKEN;
                end else if (w_irq) begin
                    cause_d  = w_irq_cause;
                    i_or_e_d = 1'b1;
                    state_d  = ST_TRAP_TAKEN;
                end else if (w_mret) begin
                    state_d  = ST_TRAP_RETURN;
                end
            end
            default: state_d = ST_OPERATING;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= ST_RESET;
            cause_q  <= '0;
            i_or_e_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            i_or_e_q <= i_or_e_d;
        end
    end

    assign cause_out      = cause_q;
    assign i_or_e_out     = i_or_e_q;
    assign trap_taken_out = (state_q == ST_TRAP_TAKEN);
    assign set_cause_out  = (state_q == ST_TRAP_TAKEN);
    assign set_epc_out    = (state_q == ST_TRAP_TAKEN);
    assign mie_clear_out  = (state_q == ST_TRAP_TAKEN);
    assign mie_set_out    = (state_q == ST_TRAP_RETURN);
    assign flush_out      = (state_q != ST_OPERATING);

    always_comb begin
        pc_src_out = 2'b11;
        case (state_q)
            ST_RESET:       pc_src_out = 2'b00;
            ST_TRAP_RETURN: pc_src_out = 2'b01;
            ST_TRAP_TAKEN:  pc_src_out = 2'b10;
            default:        pc_src_out = 2'b11;
        endcase
    end

    // mret retires in TRAP_RETURN rather than in the cycle it is decoded.
    assign instret_inc_out = ((state_q == ST_OPERATING) && !(w_exc || w_irq || w_mret)) ||
                             (state_q == ST_TRAP_RETURN);

endmodule

`default_nettype wire

// File: tb/tb_msrv32_machine_control.sv
// ============================================================================
//  Module   : tb_msrv32_machine_control
//  Purpose  : Directed self-checking bench for msrv32_machine_control.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msrv32_machine_control;

    localparam int CAUSE_W = 4;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in;
    logic [4:0] opcode_6_to_2_in;
    logic [2:0] funct3_in;
    logic [6:0] funct7_in;
    logic [4:0] rs2_addr_in;
    logic mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
    logic trap_taken_out, i_or_e_out, set_cause_out, set_epc_out;
    logic mie_clear_out, mie_set_out, instret_inc_out, flush_out;
    logic [CAUSE_W-1:0] cause_out;
    logic [1:0] pc_src_out;

    int n_tests = 0;
    int n_fail  = 0;

    msrv32_machine_control #(.CAUSE_W(CAUSE_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .illegal_instr_in(illegal_instr_in), .misaligned_load_in(misaligned_load_in),
        .misaligned_store_in(misaligned_store_in), .misaligned_instr_in(misaligned_instr_in),
        .opcode_6_to_2_in(opcode_6_to_2_in), .funct3_in(funct3_in),
        .funct7_in(funct7_in), .rs2_addr_in(rs2_addr_in),
        .mie_in(mie_in), .meie_in(meie_in), .mtie_in(mtie_in), .msie_in(msie_in),
        .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
        .trap_taken_out(trap_taken_out), .i_or_e_out(i_or_e_out), .cause_out(cause_out),
        .set_cause_out(set_cause_out), .set_epc_out(set_epc_out),
        .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out),
        .instret_inc_out(instret_inc_out), .pc_src_out(pc_src_out), .flush_out(flush_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        illegal_instr_in = 0; misaligned_load_in = 0; misaligned_store_in = 0;
        misaligned_instr_in = 0; opcode_6_to_2_in = 5'b01100; funct3_in = 0;
        funct7_in = 0; rs2_addr_in = 0;
        mie_in = 0; meie_in = 0; mtie_in = 0; msie_in = 0;
        meip_in = 0; mtip_in = 0; msip_in = 0;
    endtask

    task automatic sys(input logic [6:0] f7, input logic [4:0] rs2);
        opcode_6_to_2_in = 5'b11100; funct3_in = 3'b000;
        funct7_in = f7; rs2_addr_in = rs2;
    endtask

    // Outputs are sampled 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic expect_trap(input string tag, input logic [3:0] c, input logic ie);
        check({tag, ".trap"},  trap_taken_out, 1);
        check({tag, ".cause"}, cause_out, c);
        check({tag, ".ie"},    i_or_e_out, ie);
        check({tag, ".pc"},    pc_src_out, 2'b10);
    endtask

    initial begin
        idle();
        #12;
        check("rst.pc",    pc_src_out, 2'b00);
        check("rst.flush", flush_out, 1);
        check("rst.trap",  trap_taken_out, 0);
        check("rst.cause", cause_out, 0);
        check("rst.ie",    i_or_e_out, 0);
        check("rst.inst",  instret_inc_out, 0);
        check("rst.mset",  mie_set_out, 0);
        rst_in = 1;
        tick();
        check("op.pc",    pc_src_out, 2'b11);
        check("op.flush", flush_out, 0);
        check("op.inst",  instret_inc_out, 1);

        // Illegal instruction for one cycle.
        illegal_instr_in = 1;
        #1 check("ill.inst_now", instret_inc_out, 0);
        tick();
        illegal_instr_in = 0;
        misaligned_store_in = 1;   // ignored while in TRAP_TAKEN
        expect_trap("ill", 4'd2, 0);
        check("ill.epc",   set_epc_out, 1);
        check("ill.scau",  set_cause_out, 1);
        check("ill.mclr",  mie_clear_out, 1);
        check("ill.flush", flush_out, 1);
        check("ill.inst",  instret_inc_out, 0);
        misaligned_store_in = 0;
        tick();
        check("ill.back_pc",   pc_src_out, 2'b11);
        check("ill.back_trap", trap_taken_out, 0);
        check("ill.hold",      cause_out, 2);

        // Interrupt priority: external over timer, then timer alone.
        mie_in = 1; meie_in = 1; mtie_in = 1; meip_in = 1; mtip_in = 1;
        tick();
        expect_trap("ext", 4'd11, 1);
        mie_in = 0;
        tick();
        meip_in = 0; mie_in = 1;
        tick();
        expect_trap("tmr", 4'd7, 1);
        mie_in = 0;
        tick();

        // Software beats timer.
        mie_in = 1; msie_in = 1; msip_in = 1;
        tick();
        expect_trap("sw", 4'd3, 1);
        idle();
        tick();

        // ecall beats misaligned load.
        sys(7'b0000000, 5'b00000); misaligned_load_in = 1;
        tick();
        expect_trap("ecall", 4'd11, 0);
        idle();
        tick();

        // Exception beats interrupt.
        illegal_instr_in = 1; mie_in = 1; mtie_in = 1; mtip_in = 1;
        tick();
        expect_trap("ill_irq", 4'd2, 0);
        idle();
        tick();

        // ebreak, misaligned-instr over illegal, store alone, load alone.
        sys(7'b0000000, 5'b00001);
        tick();
        expect_trap("ebrk", 4'd3, 0);
        idle(); tick();
        misaligned_instr_in = 1; illegal_instr_in = 1;
        tick();
        expect_trap("mis_i", 4'd0, 0);
        idle(); tick();
        misaligned_store_in = 1;
        tick();
        expect_trap("st", 4'd6, 0);
        idle(); tick();
        misaligned_load_in = 1; misaligned_store_in = 1;
        tick();
        expect_trap("ld", 4'd4, 0);
        idle(); tick();

        // mret.
        sys(7'b0011000, 5'b00010);
        #1 check("mret.inst_now", instret_inc_out, 0);
        tick();
        idle();
        check("mret.mset",  mie_set_out, 1);
        check("mret.pc",    pc_src_out, 2'b01);
        check("mret.flush", flush_out, 1);
        check("mret.inst",  instret_inc_out, 1);
        check("mret.trap",  trap_taken_out, 0);
        check("mret.scau",  set_cause_out, 0);
        check("mret.mclr",  mie_clear_out, 0);
        check("mret.cause", cause_out, 4);
        tick();
        check("mret.back", pc_src_out, 2'b11);

        // mret with illegal: the exception wins.
        sys(7'b0011000, 5'b00010); illegal_instr_in = 1;
        tick();
        expect_trap("mret_ill", 4'd2, 0);
        check("mret_ill.mset", mie_set_out, 0);
        idle(); tick();

        // Pending interrupts masked by mie_in=0.
        meie_in = 1; meip_in = 1; mtie_in = 1; mtip_in = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check("mask.inst", instret_inc_out, 1);
            tick();
            check("mask.trap", trap_taken_out, 0);
        end
        idle();

        // Reset asserted in the middle of TRAP_TAKEN.
        illegal_instr_in = 1;
        tick();
        illegal_instr_in = 0;
        check("rmid.trap_before", trap_taken_out, 1);
        rst_in = 0;
        #1;
        check("rmid.pc",    pc_src_out, 2'b00);
        check("rmid.flush", flush_out, 1);
        check("rmid.trap",  trap_taken_out, 0);
        check("rmid.cause", cause_out, 0);
        @(negedge clk_in);
        rst_in = 1;
        tick();
        check("rmid.op_pc", pc_src_out, 2'b11);
        check("rmid.op_fl", flush_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
